detector_paso: RTL and testbench

- Direction decoder for a two-sensor passage; sits directly upstream of the occupancy/LED stage (mostrarFPGA) and produces what it consumes.
- Takes raw sensor inputs BTN1 (outer) and BTN4 (inner), then synchronises and debounces them.
- Tracks the 4-phase crossing sequence and emits one-cycle ENTRADA / SALIDA pulses.
- Incomplete, invalid or stalled sequences produce an ERROR pulse instead of a count event.

---
 rtl/detector_paso.sv | 197 +++++++++++++++++++
 tb/tb_detector_paso.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_paso.sv
// detector_paso: direction decoder for a two-sensor passage.
// BTN1 is the outer sensor (A), BTN4 the inner sensor (B). Each raw input is
// synchronised and, when DETECTOR_DEBOUNCE_EN is defined, debounced over
// DB_CYCLES samples. A 4-phase sequence FSM turns the filtered (A,B) pair into
// one-cycle ENTRADA / SALIDA pulses, or an ERROR pulse for invalid or stalled
// sequences. ESTADO exposes the registered FSM state for debug.
// Optional feature macro: DETECTOR_DEBOUNCE_EN (undefined: filtered = synchronised).
module detector_paso #(
   parameter int DB_CYCLES      = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN1,
   input  logic       BTN4,
   output logic       ENTRADA,
   output logic       SALIDA,
   output logic       ERROR,
   output logic [2:0] ESTADO
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      E1       = 3'd1,
      E2       = 3'd2,
      E3       = 3'd3,
      S1       = 3'd4,
      S2       = 3'd5,
      S3       = 3'd6,
      WAIT_CLR = 3'd7
   } state_t;

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   // Reject parameter values the counters cannot represent.
   if (DB_CYCLES < 1) begin : g_bad_db
      $error("detector_paso: DB_CYCLES must be at least 1");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("detector_paso: TIMEOUT_CYCLES must be at least 2");
   end

   // Bit 1 carries A (BTN1), bit 0 carries B (BTN4).
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    filt;
   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] tcnt;
   logic          ent_nxt;
   logic          sal_nxt;
   logic          err_nxt;
   logic          timeout;

   // Two-flop synchroniser for both raw sensor inputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {BTN1, BTN4};
         sync2 <= sync1;
      end
   end

`ifdef DETECTOR_DEBOUNCE_EN
   localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DW-1:0] DMAX = DW'(DB_CYCLES - 1);

   logic [DW-1:0] db_cnt [2];

   // Debounce: the filtered bit follows the synchronised bit only after it has
   // differed for DB_CYCLES consecutive samples; any agreement restarts the count.
   always_ff @(posedge CLK) begin
      if (RST) begin
         filt <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DMAX) begin
               filt[i]   <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   // Without debouncing the FSM sees the synchroniser output directly.
   assign filt = sync2;
`endif

   // State, registered pulses and the stall timer.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         tcnt    <= '0;
         ENTRADA <= 1'b0;
         SALIDA  <= 1'b0;
         ERROR   <= 1'b0;
      end else begin
         state   <= state_nxt;
         ENTRADA <= ent_nxt;
         SALIDA  <= sal_nxt;
         ERROR   <= err_nxt;
         if (state_nxt != state || state == IDLE || state == WAIT_CLR)
            tcnt <= '0;
         else
            tcnt <= tcnt + 1'b1;
      end
   end

   // Next-state and pulse decode from the filtered (A,B) pair.
   always_comb begin
      state_nxt = state;
      ent_nxt   = 1'b0;
      sal_nxt   = 1'b0;
      err_nxt   = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            case (filt)
               2'b10: state_nxt = E1;
               2'b01: state_nxt = S1;
               2'b11: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: state_nxt = IDLE;
            endcase
         end
         E1: begin
            case (filt)
               2'b11: state_nxt = E2;
               2'b00: state_nxt = IDLE;
               2'b01: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: state_nxt = E1;
            endcase
         end
         E2: begin
            case (filt)
               2'b01: state_nxt = E3;
               2'b10: state_nxt = E1;
               2'b00: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: state_nxt = E2;
            endcase
         end
         E3: begin
            case (filt)
               2'b00: begin state_nxt = IDLE; ent_nxt = 1'b1; end
               2'b11: state_nxt = E2;
               2'b10: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: state_nxt = E3;
            endcase
         end
         S1: begin
            case (filt)
               2'b11: state_nxt = S2;
               2'b00: state_nxt = IDLE;
               2'b10: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: state_nxt = S1;
            endcase
         end
         S2: begin
            case (filt)
               2'b10: state_nxt = S3;
               2'b01: state_nxt = S1;
               2'b00: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: state_nxt = S2;
            endcase
         end
         S3: begin
            case (filt)
               2'b00: begin state_nxt = IDLE; sal_nxt = 1'b1; end
               2'b11: state_nxt = S2;
               2'b01: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
               default: state_nxt = S3;
            endcase
         end
         default: begin
            // WAIT_CLR: hold until both sensors are released.
            if (filt == 2'b00) state_nxt = IDLE;
         end
      endcase
      // A sequence that has not moved for TIMEOUT_CYCLES cycles is aborted.
      if (state != IDLE && state != WAIT_CLR && state_nxt == state && tcnt == TMAX)
         timeout = 1'b1;
      if (timeout) begin
         state_nxt = WAIT_CLR;
         err_nxt   = 1'b1;
      end
   end

   assign ESTADO = state;

endmodule

// File: tb/tb_detector_paso.sv
// Directed bench for detector_paso: entry, exit, bounce, retreat, invalid
// sequence, timeout and mid-sequence reset.
module tb_detector_paso;

`ifdef DETECTOR_DEBOUNCE_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 3;
`endif

   logic       CLK;
   logic       RST;
   logic       BTN1;
   logic       BTN4;
   logic       ENTRADA;
   logic       SALIDA;
   logic       ERROR;
   logic [2:0] ESTADO;

   int n_checks;
   int n_err;
   int n_ent;
   int n_sal;
   int n_errp;
   int n_overlap;
   int b_ent;
   int b_sal;
   int b_errp;

   detector_paso #(
      .DB_CYCLES(4),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .BTN1(BTN1),
      .BTN4(BTN4),
      .ENTRADA(ENTRADA),
      .SALIDA(SALIDA),
      .ERROR(ERROR),
      .ESTADO(ESTADO)
   );

   // Clock: 10 time-unit period.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Pulse monitor, sampled on the falling edge.
   initial begin
      n_ent = 0; n_sal = 0; n_errp = 0; n_overlap = 0;
   end
   always @(negedge CLK) begin
      if (!RST) begin
         if (ENTRADA === 1'b1) n_ent++;
         if (SALIDA === 1'b1) n_sal++;
         if (ERROR === 1'b1) n_errp++;
         if ((32'(ENTRADA) + 32'(SALIDA) + 32'(ERROR)) > 32'd1) n_overlap++;
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic hold(input logic a, input logic b, input int n);
      BTN1 = a;
      BTN4 = b;
      tick(n);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic mark();
      b_ent = n_ent; b_sal = n_sal; b_errp = n_errp;
   endtask

   task automatic check_counts(input string tag, input int e, input int s, input int r);
      check({tag, ".entrada"}, 32'(n_ent - b_ent), 32'(e));
      check({tag, ".salida"}, 32'(n_sal - b_sal), 32'(s));
      check({tag, ".error"}, 32'(n_errp - b_errp), 32'(r));
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      RST  = 1'b1;
      BTN1 = 1'b0;
      BTN4 = 1'b0;
      tick(3);
      check("reset.estado", 32'(ESTADO), 32'd0);
      check("reset.entrada", 32'(ENTRADA), 32'd0);
      check("reset.salida", 32'(SALIDA), 32'd0);
      check("reset.error", 32'(ERROR), 32'd0);
      RST = 1'b0;
      tick(5);
      check("idle.estado", 32'(ESTADO), 32'd0);

      // Single entry with exact latency and pulse width.
      mark();
      hold(1'b1, 1'b0, LAT - 1);
      check("entry.e1_early", 32'(ESTADO), 32'd0);
      tick(1);
      check("entry.e1", 32'(ESTADO), 32'd1);
      tick(20 - LAT);
      hold(1'b1, 1'b1, 20);
      check("entry.e2", 32'(ESTADO), 32'd2);
      hold(1'b0, 1'b1, 20);
      check("entry.e3", 32'(ESTADO), 32'd3);
      hold(1'b0, 1'b0, LAT - 1);
      check("entry.pulse_early", 32'(ENTRADA), 32'd0);
      check("entry.e3_hold", 32'(ESTADO), 32'd3);
      tick(1);
      check("entry.pulse", 32'(ENTRADA), 32'd1);
      check("entry.idle", 32'(ESTADO), 32'd0);
      tick(1);
      check("entry.pulse_width", 32'(ENTRADA), 32'd0);
      tick(18);
      check_counts("entry", 1, 0, 0);

      // Single exit with exact latency.
      mark();
      hold(1'b0, 1'b1, 20);
      check("exit.s1", 32'(ESTADO), 32'd4);
      hold(1'b1, 1'b1, 20);
      check("exit.s2", 32'(ESTADO), 32'd5);
      hold(1'b1, 1'b0, 20);
      check("exit.s3", 32'(ESTADO), 32'd6);
      hold(1'b0, 1'b0, LAT - 1);
      check("exit.pulse_early", 32'(SALIDA), 32'd0);
      tick(1);
      check("exit.pulse", 32'(SALIDA), 32'd1);
      check("exit.idle", 32'(ESTADO), 32'd0);
      tick(1);
      check("exit.pulse_width", 32'(SALIDA), 32'd0);
      tick(18);
      check_counts("exit", 0, 1, 0);

      // Seven back-to-back entries, then seven exits.
      mark();
      for (int k = 0; k < 7; k++) begin
         hold(1'b1, 1'b0, 20);
         hold(1'b1, 1'b1, 20);
         hold(1'b0, 1'b1, 20);
         hold(1'b0, 1'b0, 20);
      end
      for (int k = 0; k < 7; k++) begin
         hold(1'b0, 1'b1, 20);
         hold(1'b1, 1'b1, 20);
         hold(1'b1, 1'b0, 20);
         hold(1'b0, 1'b0, 20);
      end
      check_counts("burst", 7, 7, 0);
      check("burst.estado", 32'(ESTADO), 32'd0);

      // Bounce on BTN1: too short to pass the debouncer.
      mark();
      hold(1'b1, 1'b0, 1);
      hold(1'b0, 1'b0, 1);
      hold(1'b1, 1'b0, 1);
      BTN1 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick(1);
`ifdef DETECTOR_DEBOUNCE_EN
         if (k < 10) check("bounce.estado_cycle", 32'(ESTADO), 32'd0);
`endif
      end
      check("bounce.estado", 32'(ESTADO), 32'd0);
      check_counts("bounce", 0, 0, 0);

      // Retreat from E1.
      mark();
      hold(1'b1, 1'b0, 20);
      check("retreat.e1", 32'(ESTADO), 32'd1);
      hold(1'b0, 1'b0, 20);
      check("retreat.idle", 32'(ESTADO), 32'd0);
      check_counts("retreat", 0, 0, 0);

      // Invalid jump E1 (10) -> 01.
      mark();
      hold(1'b1, 1'b0, 20);
      hold(1'b0, 1'b1, LAT - 1);
      check("invalid.err_early", 32'(ERROR), 32'd0);
      tick(1);
      check("invalid.err", 32'(ERROR), 32'd1);
      check("invalid.wait", 32'(ESTADO), 32'd7);
      tick(1);
      check("invalid.err_width", 32'(ERROR), 32'd0);
      check("invalid.wait_hold", 32'(ESTADO), 32'd7);
      hold(1'b0, 1'b0, 20);
      check("invalid.idle", 32'(ESTADO), 32'd0);
      check_counts("invalid", 0, 0, 1);

      // Stall in E1: ERROR exactly 64 cycles after entering E1.
      mark();
      hold(1'b1, 1'b0, LAT);
      check("timeout.e1", 32'(ESTADO), 32'd1);
      tick(63);
      check("timeout.err_early", 32'(ERROR), 32'd0);
      check("timeout.e1_hold", 32'(ESTADO), 32'd1);
      tick(1);
      check("timeout.err", 32'(ERROR), 32'd1);
      check("timeout.wait", 32'(ESTADO), 32'd7);
      tick(100 - LAT - 64);
      check("timeout.wait_hold", 32'(ESTADO), 32'd7);
      hold(1'b0, 1'b0, 20);
      check("timeout.idle", 32'(ESTADO), 32'd0);
      check_counts("timeout", 0, 0, 1);

      // Reset while in E2: sequence abandoned, no pulse.
      mark();
      hold(1'b1, 1'b0, 20);
      hold(1'b1, 1'b1, 20);
      check("rstmid.e2", 32'(ESTADO), 32'd2);
      RST = 1'b1;
      tick(1);
      check("rstmid.estado_rst", 32'(ESTADO), 32'd0);
      RST  = 1'b0;
      BTN1 = 1'b0;
      BTN4 = 1'b0;
      tick(20);
      check("rstmid.estado", 32'(ESTADO), 32'd0);
      check("rstmid.entrada", 32'(ENTRADA), 32'd0);
      check("rstmid.salida", 32'(SALIDA), 32'd0);
      check("rstmid.error", 32'(ERROR), 32'd0);
      check_counts("rstmid", 0, 0, 0);

      check("pulses.exclusive", 32'(n_overlap), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
